// File: rtl/rsa_key_setup_ctrl.sv
// rsa_key_setup_ctrl
// Sequencing controller for RSA public-key setup. Accepts P, Q and E through
// a start/busy/done handshake. Computes N = P*Q and T = (P-1)*(Q-1) on one
// shared shift-add multiplier (one multiplier bit per cycle, LSB first). It
// then screens E and runs a bit-serial binary GCD to decide key validity.
//
// Optional feature, enabled by defining RSA_CYCLE_COUNT_EN:
//   adds output cycle_count[15:0], the saturating number of busy cycles of
//   the most recent job.
module rsa_key_setup_ctrl #(
  parameter  int unsigned KEY_W  = 256,
  localparam int unsigned HALF_W = KEY_W / 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [HALF_W-1:0] P,
  input  logic [HALF_W-1:0] Q,
  input  logic [KEY_W-1:0]  E,
  output logic              busy,
  output logic              done,
  output logic              key_valid,
  output logic [2:0]        err_code,
  output logic [KEY_W-1:0]  N,
  output logic [KEY_W-1:0]  T
`ifdef RSA_CYCLE_COUNT_EN
  ,
  output logic [15:0]       cycle_count
`endif
);

  localparam int unsigned GCD_MAX = 3 * KEY_W;
  localparam int unsigned CNT_W   = $clog2(GCD_MAX + 1);

  localparam logic [2:0] ERR_OK    = 3'd0;
  localparam logic [2:0] ERR_PQ    = 3'd1;
  localparam logic [2:0] ERR_RANGE = 3'd2;
  localparam logic [2:0] ERR_EVEN  = 3'd3;
  localparam logic [2:0] ERR_GCD   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_N,
    S_MUL_T,
    S_CHECK,
    S_GCD,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [HALF_W-1:0]   p_q, p_d;
  logic [HALF_W-1:0]   q_q, q_d;
  logic [KEY_W-1:0]    e_q, e_d;
  logic [KEY_W-1:0]    acc_q, acc_d;
  logic [KEY_W-1:0]    mcand_q, mcand_d;
  logic [HALF_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [KEY_W-1:0]    ga_q, ga_d;
  logic [KEY_W-1:0]    gb_q, gb_d;
  logic [KEY_W-1:0]    n_q, n_d;
  logic [KEY_W-1:0]    t_q, t_d;
  logic                kv_q, kv_d;
  logic [2:0]          err_q, err_d;

  logic [KEY_W-1:0]    mul_sum;
  logic [HALF_W-1:0]   p_m1;
  logic [HALF_W-1:0]   q_m1;
  logic                mul_last;
  logic                gcd_last;

  // Shared multiplier datapath and operand decrements for the totient pass.
  always_comb begin
    mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    p_m1     = p_q - HALF_W'(1);
    q_m1     = q_q - HALF_W'(1);
    mul_last = (cnt_q == CNT_W'(HALF_W - 1));
    gcd_last = (cnt_q == CNT_W'(GCD_MAX - 1));
  end

  // Next-state and datapath update for the setup sequence.
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    q_d      = q_q;
    e_d      = e_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    ga_d     = ga_q;
    gb_d     = gb_q;
    n_d      = n_q;
    t_d      = t_q;
    kv_d     = kv_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          p_d      = P;
          q_d      = Q;
          e_d      = E;
          kv_d     = 1'b0;
          err_d    = ERR_OK;
          acc_d    = '0;
          mcand_d  = KEY_W'(P);
          mplier_d = Q;
          cnt_d    = '0;
          state_d  = S_MUL_N;
        end
      end

      S_MUL_N: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (mul_last) begin
          // Capture N and reload the engine with P-1, Q-1 in the same cycle.
          n_d      = mul_sum;
          acc_d    = '0;
          mcand_d  = KEY_W'(p_m1);
          mplier_d = q_m1;
          cnt_d    = '0;
          state_d  = S_MUL_T;
        end
      end

      S_MUL_T: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (mul_last) begin
          t_d     = mul_sum;
          cnt_d   = '0;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if ((p_q < HALF_W'(2)) || (q_q < HALF_W'(2))) begin
          err_d   = ERR_PQ;
          state_d = S_DONE;
        end else if ((e_q <= KEY_W'(1)) || (e_q >= t_q)) begin
          err_d   = ERR_RANGE;
          state_d = S_DONE;
        end else if (!e_q[0]) begin
          err_d   = ERR_EVEN;
          state_d = S_DONE;
        end else begin
          ga_d    = t_q;
          gb_d    = e_q;
          cnt_d   = '0;
          state_d = S_GCD;
        end
      end

      S_GCD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if ((ga_q == '0) || gcd_last) begin
          state_d = S_DONE;
          if (gb_q == KEY_W'(1)) begin
            kv_d  = 1'b1;
            err_d = ERR_OK;
          end else begin
            kv_d  = 1'b0;
            err_d = ERR_GCD;
          end
        end else if (!ga_q[0]) begin
          ga_d = ga_q >> 1;
        end else if (ga_q >= gb_q) begin
          ga_d = ga_q - gb_q;
        end else begin
          // b stays odd: a is odd here, so the swap hands b an odd value.
          ga_d = gb_q;
          gb_d = ga_q;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      p_q      <= '0;
      q_q      <= '0;
      e_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      ga_q     <= '0;
      gb_q     <= '0;
      n_q      <= '0;
      t_q      <= '0;
      kv_q     <= 1'b0;
      err_q    <= ERR_OK;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      q_q      <= q_d;
      e_q      <= e_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      ga_q     <= ga_d;
      gb_q     <= gb_d;
      n_q      <= n_d;
      t_q      <= t_d;
      kv_q     <= kv_d;
      err_q    <= err_d;
    end
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    busy      = (state_q == S_MUL_N) || (state_q == S_MUL_T) ||
                (state_q == S_CHECK) || (state_q == S_GCD);
    done      = (state_q == S_DONE);
    key_valid = kv_q;
    err_code  = err_q;
    N         = n_q;
    T         = t_q;
  end

`ifdef RSA_CYCLE_COUNT_EN
  logic [15:0] cyc_q;

  // Busy-cycle counter: cleared on acceptance, saturating, idle outside busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      cyc_q <= '0;
    end else if (busy && (cyc_q != '1)) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end

  assign cycle_count = cyc_q;
`endif

endmodule

// File: tb/tb_rsa_key_setup_ctrl.sv
// Directed bench for rsa_key_setup_ctrl (KEY_W=256, HALF_W=128).
module tb_rsa_key_setup_ctrl;

  localparam int unsigned KEY_W  = 256;
  localparam int unsigned HALF_W = KEY_W / 2;
  localparam int unsigned BUDGET = 2 * HALF_W + 3 * KEY_W + 20;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [HALF_W-1:0] P;
  logic [HALF_W-1:0] Q;
  logic [KEY_W-1:0]  E;
  logic              busy;
  logic              done;
  logic              key_valid;
  logic [2:0]        err_code;
  logic [KEY_W-1:0]  N;
  logic [KEY_W-1:0]  T;
`ifdef RSA_CYCLE_COUNT_EN
  logic [15:0]       cycle_count;
`endif

  rsa_key_setup_ctrl #(.KEY_W(KEY_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .P         (P),
    .Q         (Q),
    .E         (E),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid),
    .err_code  (err_code),
    .N         (N),
    .T         (T)
`ifdef RSA_CYCLE_COUNT_EN
    ,
    .cycle_count (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Results of the last run_job: lat = clock edges from the accepting edge
  // up to the edge that raises done (so the inclusive cycle span is lat+1).
  int unsigned lat;
  int unsigned busy_len;
  bit          timed_out;

  // Reference binary GCD: step count g (exit step included) and gcd==1 flag.
  function automatic int unsigned gcd_steps(input logic [KEY_W-1:0] a0,
                                            input logic [KEY_W-1:0] b0,
                                            output bit coprime);
    logic [KEY_W-1:0] a, b, tmp;
    int unsigned g;
    a = a0;
    b = b0;
    g = 0;
    for (int unsigned k = 0; k < 4 * KEY_W; k++) begin
      g++;
      if (a == '0) break;
      if (!a[0]) a = a >> 1;
      else if (a >= b) a = a - b;
      else begin
        tmp = a; a = b; b = tmp;
      end
    end
    coprime = (b == KEY_W'(1));
    return g;
  endfunction

  task automatic run_job(input logic [HALF_W-1:0] p, input logic [HALF_W-1:0] q,
                         input logic [KEY_W-1:0] e);
    P = p; Q = q; E = e; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; busy_len = 0; timed_out = 1'b0;
    while (done !== 1'b1) begin
      if (lat > BUDGET) begin
        timed_out = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_len++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; P = '0; Q = '0; E = '0;
    #12;
    total++;
    if ({busy, done, key_valid, err_code} !== 6'd0 || N !== '0 || T !== '0) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b kv=%b err=%0d N=%0d T=%0d want all 0",
               busy, done, key_valid, err_code, N, T);
    end
`ifdef RSA_CYCLE_COUNT_EN
    total++;
    if (cycle_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_cycle_count: got %0d want 0", cycle_count);
    end
`endif
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  // Shared result checks for a finished job, inline per scenario name.
  task automatic test_job(input string name, input logic [HALF_W-1:0] p,
                          input logic [HALF_W-1:0] q, input logic [KEY_W-1:0] e,
                          input logic [KEY_W-1:0] exp_n, input logic [KEY_W-1:0] exp_t,
                          input bit exp_kv, input logic [2:0] exp_err,
                          input int unsigned exp_g);
    run_job(p, q, e);
    total++;
    if (timed_out) begin
      bad++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, BUDGET);
    end
    total++;
    if (N !== exp_n || T !== exp_t) begin
      bad++;
      $display("FAIL %s_NT: N=%0d T=%0d want N=%0d T=%0d", name, N, T, exp_n, exp_t);
    end
    total++;
    if (key_valid !== exp_kv || err_code !== exp_err) begin
      bad++;
      $display("FAIL %s_result: kv=%b err=%0d want kv=%b err=%0d",
               name, key_valid, err_code, exp_kv, exp_err);
    end
    total++;
    if (lat + 1 !== 2 * HALF_W + 3 + exp_g) begin
      bad++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat + 1, 2 * HALF_W + 3 + exp_g);
    end
    total++;
    if (busy !== 1'b0 || busy_len !== 2 * HALF_W + 1 + exp_g) begin
      bad++;
      $display("FAIL %s_busy: busy_at_done=%b len=%0d want 0 len=%0d",
               name, busy, busy_len, 2 * HALF_W + 1 + exp_g);
    end
`ifdef RSA_CYCLE_COUNT_EN
    total++;
    if (cycle_count !== 16'(busy_len)) begin
      bad++;
      $display("FAIL %s_cycle_count: got %0d want %0d", name, cycle_count, busy_len);
    end
`endif
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || N !== exp_n || T !== exp_t || err_code !== exp_err) begin
      bad++;
      $display("FAIL %s_hold: done=%b N=%0d T=%0d err=%0d want 0 %0d %0d %0d",
               name, done, N, T, err_code, exp_n, exp_t, exp_err);
    end
  endtask

  task automatic test_valid_key;
    bit cp;
    int unsigned g;
    g = gcd_steps(KEY_W'(3120), KEY_W'(17), cp);
    test_job("valid", 61, 53, 17, 3233, 3120, 1'b1, 3'd0, g);
  endtask

  task automatic test_gcd_reject;
    bit cp;
    int unsigned g;
    g = gcd_steps(KEY_W'(3120), KEY_W'(15), cp);
    test_job("gcd15", 61, 53, 15, 3233, 3120, 1'b0, 3'd4, g);
  endtask

  task automatic test_range;
    test_job("e_big", 61, 53, 4000, 3233, 3120, 1'b0, 3'd2, 0);
    test_job("e_one", 61, 53, 1, 3233, 3120, 1'b0, 3'd2, 0);
    test_job("e_eqT", 61, 53, 3120, 3233, 3120, 1'b0, 3'd2, 0);
  endtask

  task automatic test_even;
    test_job("e_even", 61, 53, 18, 3233, 3120, 1'b0, 3'd3, 0);
  endtask

  task automatic test_small_prime;
    // T=0 here, so E>=T would also fail; the P/Q error must win.
    test_job("p_one", 1, 53, 17, 53, 0, 1'b0, 3'd1, 0);
  endtask

  task automatic test_start_ignored;
    int unsigned dones;
    int unsigned cyc;
    P = 61; Q = 53; E = 17; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    cyc = 1;
    while (dones == 0 && cyc < BUDGET) begin
      if (cyc == 10) begin
        P = 7; Q = 11; E = 3; start = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) dones++;
    end
    total++;
    if (N !== KEY_W'(3233) || T !== KEY_W'(3120) || key_valid !== 1'b1 || err_code !== 3'd0) begin
      bad++;
      $display("FAIL restart_result: N=%0d T=%0d kv=%b err=%0d want 3233 3120 1 0",
               N, T, key_valid, err_code);
    end
    // start stays high across the DONE cycle and must still be ignored there.
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL restart_done_cycle: busy=%b want 0", busy);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones !== 1) begin
      bad++;
      $display("FAIL restart_done_count: got %0d want 1", dones);
    end
  endtask

  task automatic test_reset_mid_gcd;
    int unsigned dones;
    bit cp;
    int unsigned g;
    g = gcd_steps(KEY_W'(3120), KEY_W'(17), cp);
    P = 61; Q = 53; E = 17; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Edge 2*HALF_W+2 enters GCD; stop one step into it.
    for (int unsigned i = 1; i < 2 * HALF_W + 3; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_pre: busy=%b done=%b want 1 0", busy, done);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({busy, done, key_valid, err_code} !== 6'd0 || N !== '0 || T !== '0) begin
      bad++;
      $display("FAIL abort_outputs: busy=%b done=%b kv=%b err=%0d N=%0d T=%0d want all 0",
               busy, done, key_valid, err_code, N, T);
    end
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int unsigned i = 0; i < g + 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d active cycles want 0", dones);
    end
    test_job("after_abort", 61, 53, 17, 3233, 3120, 1'b1, 3'd0, g);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; P = '0; Q = '0; E = '0;
    test_reset();
    test_valid_key();
    test_gcd_reject();
    test_range();
    test_even();
    test_small_prime();
    test_start_ignored();
    test_reset_mid_gcd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
